switch_conditioner: RTL and testbench
=====================================

Name: switch_conditioner

Overview:
Upstream input stage for the jackpot game logic. It synchronises the four asynchronous slide-switch inputs into the clock domain, debounces each channel independently, and produces clean levels plus single-cycle edge pulses. SW_STABLE drives the game block's SWITCHES input directly. SW_RISE/SW_FALL are available for edge-triggered consumers.

Parameters:
WIDTH, 4, number of switch channels
DEBOUNCE_CYCLES, 125000, consecutive cycles a new synchronised level must persist before acceptance (1 ms at 125 MHz); legal range 1..2^CNT_W-1
CNT_W, 17, width of each per-channel debounce counter

Ports:
clock  input  1  system clock, 125 MHz, rising-edge
reset  input  1  synchronous, active-high reset
SWITCHES_RAW  input  WIDTH  raw asynchronous switch levels
SW_STABLE  output  WIDTH  debounced switch levels (to game block SWITCHES)
SW_RISE  output  WIDTH  one-cycle pulse per channel on accepted 0->1
SW_FALL  output  WIDTH  one-cycle pulse per channel on accepted 1->0
SW_ANY  output  1  OR of all SW_RISE and SW_FALL bits, same cycle

Behaviour:
- One clock; reset is synchronous and active-high. All state changes happen on the rising edge of clock.
- Reset: sync1, sync2, all counters, SW_STABLE, SW_RISE, SW_FALL and SW_ANY all go to 0 on the first edge with reset=1. Reset overrides every other action, including a count in progress.
- Synchroniser: two flops per channel: sync1<=SWITCHES_RAW; sync2<=sync1. No logic between the two flops.
- Per-channel debounce, evaluated on each edge:
  - sync2==SW_STABLE: counter<=0. No pulse.
  - sync2!=SW_STABLE and counter<DEBOUNCE_CYCLES-1: counter<=counter+1.
  - sync2!=SW_STABLE and counter==DEBOUNCE_CYCLES-1: SW_STABLE<=sync2; counter<=0; SW_RISE (if sync2=1) or SW_FALL (if sync2=0) asserted for exactly this one registered cycle.
- Latency: SW_STABLE changes on the (DEBOUNCE_CYCLES+2)th rising edge, counting the first edge that samples the new raw level, provided the level holds throughout. The edge pulse rises on the same edge as SW_STABLE.
- Bounce/glitch: any return of sync2 to SW_STABLE before acceptance clears the counter. Acceptance needs DEBOUNCE_CYCLES fresh consecutive mismatching cycles. A glitch shorter than DEBOUNCE_CYCLES never changes SW_STABLE and never pulses.
- Counter never wraps: it saturates at DEBOUNCE_CYCLES-1 only transiently, because acceptance resets it.
- Channels are fully independent. Simultaneous acceptance on several channels produces pulses on all of them in the same cycle, with a single SW_ANY cycle.
- Switch held high through reset release: SW_STABLE reads 0 after reset, then rises after the normal latency with a SW_RISE pulse. This is the intended behaviour.
- SW_RISE and SW_FALL for the same channel are never asserted together. Pulses are never wider than one cycle.
- SW_ANY is registered and aligned with the pulses, not derived combinationally from the outputs.

Test Plan (DEBOUNCE_CYCLES=4, 8 ns clock):
- Clean press: reset 50 ns, then SWITCHES_RAW=4'b0010 held -> SW_STABLE=4'b0010 on the 6th edge after the change. SW_RISE=4'b0010 and SW_ANY=1 for exactly one cycle. No other bits move.
- Bounce: SWITCHES_RAW[3] toggles 1,0,1,0,1 at 2-cycle spacing, then holds 1 -> SW_STABLE[3]=1 exactly 6 edges after the final 0->1. A single SW_RISE[3] pulse. No SW_FALL.
- Short glitch: SWITCHES_RAW[0]=1 for 3 cycles, then 0 -> SW_STABLE stays 4'b0000. SW_RISE, SW_FALL and SW_ANY never assert.
- Release: from SW_STABLE=4'b1000, drive SWITCHES_RAW=0 -> SW_STABLE=0 after 6 edges. One SW_FALL=4'b1000 pulse. No SW_RISE.
- Reset mid-count: SWITCHES_RAW=4'b0100, assert reset for 1 cycle at edge 4, then deassert -> all outputs 0 during reset. SW_STABLE[2] rises 6 edges after the first post-reset edge, not earlier.
- Simultaneous: SWITCHES_RAW 4'b0000->4'b1111 -> all four SW_STABLE bits and SW_RISE=4'b1111 on the same edge. SW_ANY high for one cycle only.

Source files
------------

// File: rtl/switch_conditioner.sv
`default_nettype none
// ============================================================================
//  Module   : switch_conditioner
//  Purpose  : Two-flop synchroniser, independent per-channel debounce and
//             registered rise/fall edge pulses for the slide-switch inputs.
//  Revision : 1.0  initial release
// ============================================================================
module switch_conditioner #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 125000,
  parameter int CNT_W           = 17
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] SWITCHES_RAW,
  output logic [WIDTH-1:0] SW_STABLE,
  output logic [WIDTH-1:0] SW_RISE,
  output logic [WIDTH-1:0] SW_FALL,
  output logic             SW_ANY
);

  // Terminal count: reaching it while still mismatching means DEBOUNCE_CYCLES
  // consecutive mismatching samples have been seen.
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_ONE  = CNT_W'(1);

  logic [WIDTH-1:0] r_sync1;
  logic [WIDTH-1:0] r_sync2;
  logic [WIDTH-1:0] w_accept;
  logic             r_any;

  // Two-stage synchroniser for the asynchronous raw levels, no logic between.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= SWITCHES_RAW;
      r_sync2 <= r_sync1;
    end
  end

  generate
    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
      logic [CNT_W-1:0] r_cnt;
      logic             r_stb;
      logic             r_rise;
      logic             r_fall;

      // A new level is accepted on the edge where the counter already holds
      // the terminal value and the synchronised level still disagrees.
      assign w_accept[i] = (r_sync2[i] != r_stb) && (r_cnt == C_LAST);

      // Debounce counter, accepted level and one-cycle edge pulses.
      always_ff @(posedge clock) begin
        if (reset) begin
          r_cnt  <= '0;
          r_stb  <= 1'b0;
          r_rise <= 1'b0;
          r_fall <= 1'b0;
        end else begin
          r_rise <= w_accept[i] & r_sync2[i];
          r_fall <= w_accept[i] & ~r_sync2[i];
          if (r_sync2[i] == r_stb) begin
            r_cnt <= '0;
          end else if (r_cnt == C_LAST) begin
            r_stb <= r_sync2[i];
            r_cnt <= '0;
          end else begin
            r_cnt <= r_cnt + C_ONE;
          end
        end
      end

      assign SW_STABLE[i] = r_stb;
      assign SW_RISE[i]   = r_rise;
      assign SW_FALL[i]   = r_fall;
    end
  endgenerate

  // Registered summary pulse, aligned with the per-channel pulses.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_any <= 1'b0;
    end else begin
      r_any <= |w_accept;
    end
  end

  assign SW_ANY = r_any;

endmodule
`default_nettype wire

// File: tb/tb_switch_conditioner.sv
`default_nettype none
// ============================================================================
//  Module   : tb_switch_conditioner
//  Purpose  : Self-checking bench for switch_conditioner (DEBOUNCE_CYCLES=4).
//  Revision : 1.0  initial release
// ============================================================================
module tb_switch_conditioner;

  localparam int W = 4;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] raw = '0;
  logic [W-1:0] sw_stable, sw_rise, sw_fall;
  logic         sw_any;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [W-1:0] stable;
    logic [W-1:0] rise;
    logic [W-1:0] fall;
    logic         any;
  } exp_t;

  exp_t sb[$];

  // Reference model state: sync pipeline, accepted level, recent sync samples.
  logic [W-1:0] m_sync1 = '0;
  logic [W-1:0] m_sync2 = '0;
  logic [W-1:0] m_stable = '0;
  logic [W-1:0] hist[$];

  switch_conditioner #(
    .WIDTH(W), .DEBOUNCE_CYCLES(D), .CNT_W(17)
  ) dut (
    .clock(clk), .reset(rst), .SWITCHES_RAW(raw),
    .SW_STABLE(sw_stable), .SW_RISE(sw_rise), .SW_FALL(sw_fall), .SW_ANY(sw_any)
  );

  always #4 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, got, exp);
    end
  endtask

  // One edge of the reference: a level is accepted once the last D samples
  // that reached the debouncer all disagree with the accepted level.
  task automatic model_step();
    exp_t e;
    logic [W-1:0] rise, fall;
    rise = '0;
    fall = '0;
    if (rst) begin
      m_sync1  = '0;
      m_sync2  = '0;
      m_stable = '0;
      hist.delete();
    end else begin
      hist.push_back(m_sync2);
      if (hist.size() > D) void'(hist.pop_front());
      for (int c = 0; c < W; c++) begin
        bit all_diff;
        all_diff = (hist.size() == D);
        foreach (hist[k]) if (hist[k][c] == m_stable[c]) all_diff = 0;
        if (all_diff) begin
          if (m_stable[c]) fall[c] = 1'b1;
          else             rise[c] = 1'b1;
          m_stable[c] = ~m_stable[c];
        end
      end
      m_sync2 = m_sync1;
      m_sync1 = raw;
    end
    e.stable = m_stable;
    e.rise   = rise;
    e.fall   = fall;
    e.any    = |(rise | fall);
    sb.push_back(e);
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Monitor: every cycle the DUT presents a set of outputs; compare on negedge.
  initial forever begin
    @(negedge clk);
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check("sb_stable", sw_stable, e.stable);
      check("sb_rise",   sw_rise,   e.rise);
      check("sb_fall",   sw_fall,   e.fall);
      check("sb_any",    {3'b000, sw_any}, {3'b000, e.any});
    end
  end

  // Watchdog.
  initial begin
    #(80000 * 8);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    logic [W-1:0] pat;
    rst = 1'b1;
    raw = '0;
    tick(7);
    check("reset_stable", sw_stable, 4'b0000);
    check("reset_pulses", sw_rise | sw_fall, 4'b0000);
    rst = 1'b0;
    tick(3);

    // Clean press on bit 1.
    raw = 4'b0010;
    tick(5);
    check("press_before", sw_stable, 4'b0000);
    tick(1);
    check("press_stable", sw_stable, 4'b0010);
    check("press_rise",   sw_rise,   4'b0010);
    check("press_any",    {3'b000, sw_any}, 4'b0001);
    tick(1);
    check("press_rise_gone", sw_rise, 4'b0000);
    raw = 4'b0000;
    tick(10);

    // Bouncing press on bit 3.
    pat = 4'b1000;
    for (int t = 0; t < 4; t++) begin
      raw = (t % 2 == 0) ? pat : 4'b0000;
      tick(2);
    end
    raw = pat;
    tick(5);
    check("bounce_before", sw_stable, 4'b0000);
    tick(1);
    check("bounce_stable", sw_stable, 4'b1000);
    check("bounce_rise",   sw_rise,   4'b1000);
    tick(6);

    // Release of bit 3.
    raw = 4'b0000;
    tick(6);
    check("release_stable", sw_stable, 4'b0000);
    check("release_fall",   sw_fall,   4'b1000);
    tick(6);

    // Short glitch on bit 0.
    raw = 4'b0001;
    tick(3);
    raw = 4'b0000;
    tick(10);
    check("glitch_stable", sw_stable, 4'b0000);

    // Reset in the middle of a count.
    raw = 4'b0100;
    tick(3);
    rst = 1'b1;
    tick(1);
    check("midrst_stable", sw_stable, 4'b0000);
    check("midrst_pulses", sw_rise | sw_fall, 4'b0000);
    rst = 1'b0;
    tick(5);
    check("midrst_before", sw_stable, 4'b0000);
    tick(1);
    check("midrst_stable_up", sw_stable, 4'b0100);
    raw = 4'b0000;
    tick(10);

    // All channels together.
    raw = 4'b1111;
    tick(6);
    check("simul_stable", sw_stable, 4'b1111);
    check("simul_rise",   sw_rise,   4'b1111);
    check("simul_any",    {3'b000, sw_any}, 4'b0001);
    tick(1);
    check("simul_any_gone", {3'b000, sw_any}, 4'b0000);
    tick(4);
    raw = 4'b0000;
    tick(10);

    // Randomised levels with mixed hold lengths and occasional resets.
    for (int n = 0; n < 120; n++) begin
      raw = raw ^ 4'($urandom_range(0, 15));
      if ($urandom_range(0, 30) == 0) begin
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
      end
      tick($urandom_range(1, 8));
    end
    tick(10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
